rr_arbiter_hold: RTL and testbench

//   Registered round-robin arbiter that shares one resource among NUM_PORTS requesters.
//   - A grant is held while the winner keeps requesting.
//   - A grant is pre-empted after MAX_HOLD cycles if any other port is waiting.
//   - Sits in front of shared datapath resources (bus, memory port) as the fair,

---
 rtl/rr_arbiter_hold.sv | 167 ++++++++++++++++
 tb/tb_rr_arbiter_hold.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: registered round-robin arbiter with grant hold and bounded tenure.
//
// A winner keeps the grant while it keeps requesting. After MAX_HOLD consecutive cycles it
// is pre-empted if any other port is waiting. MAX_HOLD = 0 disables pre-emption entirely.
// The search for a new winner starts one past the previous winner, so a port that has just
// lost the grant has the lowest priority.
//
// Optional feature: define ARB_LOCK_EN to add lock_i, which suppresses pre-emption while the
// current owner keeps requesting.
//
// Ports:
//   clk_i     clock, all state on the rising edge
//   rst_n_i   asynchronous active-low reset
//   req_i     level-sensitive request vector, bit n = port n
//   lock_i    (ARB_LOCK_EN only) hold the current grant past MAX_HOLD
//   gnt_o     registered one-hot grant, all-zero when idle
//   gnt_id_o  index of the granted port (0 when idle)
//   busy_o    high whenever gnt_o is non-zero
module rr_arbiter_hold #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned MAX_HOLD  = 4,
    localparam int unsigned ID_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_PORTS-1:0] req_i,
`ifdef ARB_LOCK_EN
    input  logic                 lock_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [ID_W-1:0]      gnt_id_o,
    output logic                 busy_o
);

    // hold_cnt needs at least one bit even when MAX_HOLD = 0 (where it is simply unused).
    localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HoldMax = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HoldOne = HCW'(1);

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;

    logic                lock_active;
    logic [NUM_PORTS-1:0] own_mask;
    logic [NUM_PORTS-1:0] others;
    logic                hold_at_max;
    logic [ID_W-1:0]     win_idle;
    logic [ID_W-1:0]     win_rot;

    // Index + 1, wrapping NUM_PORTS-1 back to 0 (works for non-power-of-two port counts).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return idx + ID_W'(1);
    endfunction

    // First set bit of req searching circularly upward from start; 0 if req is empty.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [ID_W-1:0]      start);
        logic [2*NUM_PORTS-1:0] dbl;
        logic [NUM_PORTS-1:0]   rot;
        logic [ID_W-1:0]        win;
        logic                   found;
        int unsigned            sum;
        dbl   = {req, req} >> start;
        rot   = dbl[NUM_PORTS-1:0];
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                sum = 32'(start) + i;
                if (sum >= NUM_PORTS) begin
                    sum = sum - NUM_PORTS;
                end
                win   = ID_W'(sum);
                found = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_active = lock_i;
`else
    assign lock_active = 1'b0;
`endif

    assign own_mask    = NUM_PORTS'(1) << gnt_id_q;
    assign others      = req_i & ~own_mask;
    assign hold_at_max = (MAX_HOLD != 0) && (hold_cnt_q == HoldMax);
    assign win_idle    = rr_pick(req_i, ptr_q);
    // Rotation always searches from one past the current owner.
    assign win_rot     = rr_pick(others, wrap_inc(gnt_id_q));

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d    = StGrant;
                    gnt_id_d   = win_idle;
                    ptr_d      = wrap_inc(win_idle);
                    hold_cnt_d = HoldOne;
                end
            end
            StGrant: begin
                if (!req_i[gnt_id_q]) begin
                    // Release: hand over at the same edge, no idle bubble.
                    if (|others) begin
                        gnt_id_d   = win_rot;
                        ptr_d      = wrap_inc(win_rot);
                        hold_cnt_d = HoldOne;
                    end else begin
                        state_d    = StIdle;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_at_max && !lock_active) begin
                    if (|others) begin
                        gnt_id_d = win_rot;
                        ptr_d    = wrap_inc(win_rot);
                    end
                    // Tenure restarts whether or not the owner changed.
                    hold_cnt_d = HoldOne;
                end else if (!hold_at_max && (MAX_HOLD != 0)) begin
                    hold_cnt_d = hold_cnt_q + HoldOne;
                end
                // Locked at the limit: hold_cnt stays saturated so pre-emption fires as
                // soon as the lock drops.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // All outputs decode from the same registers, so they can never disagree.
    assign busy_o   = (state_q == StGrant);
    assign gnt_o    = busy_o ? own_mask : '0;
    assign gnt_id_o = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Self-checking bench for rr_arbiter_hold (NUM_PORTS = 4, MAX_HOLD = 4).
// Expected grants are queued when each request pattern is driven and compared after the
// following clock edge.
module tb_rr_arbiter_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    rr_arbiter_hold #(
        .NUM_PORTS(4),
        .MAX_HOLD (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
`ifdef ARB_LOCK_EN
        .lock_i  (lock),
`endif
        .gnt_o   (gnt),
        .gnt_id_o(gnt_id),
        .busy_o  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive req between edges, queue the grant expected after the next edge, then compare.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] e);
        logic [3:0] want;
        @(negedge clk);
        req = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check({tag, ".gnt"}, 32'(gnt), 32'(want));
        check({tag, ".id"}, 32'(gnt_id), 32'(idx_of(want)));
        check({tag, ".busy"}, 32'(busy), 32'(|want));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        check({tag, ".gnt"}, 32'(gnt), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".id"}, 32'(gnt_id), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e;
        rst_n = 1'b0;
        req   = 4'b1111;
`ifdef ARB_LOCK_EN
        lock  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.id", 32'(gnt_id), 32'h0);
        rst_n = 1'b1;

        // First edge after reset grants port 0, then full rotation with 4-cycle tenure.
        step("first", 4'b1111, 4'b0001);
        for (int k = 0; k < 3; k++) step("rot0", 4'b1111, 4'b0001);
        for (int p = 1; p < 4; p++) begin
            e = 4'b0001 << p;
            for (int k = 0; k < 4; k++) step("rot", 4'b1111, e);
        end
        step("rot_wrap", 4'b1111, 4'b0001);
        step("drop_all", 4'b0000, 4'b0000);

        // Fresh start with ptr = 0; release hands over without a bubble.
        reset_pulse("rst2");
        step("t2_first", 4'b0101, 4'b0001);
        step("t2_handover", 4'b0100, 4'b0100);

        // Lone requester keeps the grant across the hold limit.
        for (int k = 0; k < 12; k++) step("lone", 4'b0010, 4'b0010);

        // Reset mid-grant drops the grant immediately and returns ptr to 0.
        step("t5_setup", 4'b0100, 4'b0100);
        reset_pulse("rst_mid");
        step("t5_after", 4'b1100, 4'b0100);
        step("t5_hold", 4'b1100, 4'b0100);
        step("t5_rel", 4'b1000, 4'b1000);
        step("t5_idle", 4'b0000, 4'b0000);

        // Two competitors alternate every 4 cycles.
        for (int k = 0; k < 4; k++) step("pair1", 4'b0110, 4'b0010);
        for (int k = 0; k < 4; k++) step("pair2", 4'b0110, 4'b0100);
        step("pair_back", 4'b0110, 4'b0010);

`ifdef ARB_LOCK_EN
        step("lk_idle", 4'b0000, 4'b0000);
        reset_pulse("rst_lk");
        lock = 1'b1;
        for (int k = 0; k < 10; k++) step("lock", 4'b1111, 4'b0001);
        lock = 1'b0;
        step("unlock", 4'b1111, 4'b0010);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
